pos_mem_arbiter: RTL

Arbiter and sequencer for one single-port particle-position RAM (32-bit words, registered output, 2-cycle read latency). It shares that RAM between one write requester (motion-update writeback) and two read requesters (home-cell and neighbour-cell readers feeding the range-limited force pipeline). It drives the RAM's address/data/rden/wren pins from registers and returns read data tagged with the requester ID. It sits directly between the position RAM instance and the cell readers/motion-update unit.

---
 rtl/pos_mem_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/pos_mem_arbiter.sv
// Shares one single-port position RAM between a writer and two readers: one grant per cycle, registered RAM command,
// read data tagged with the reader id RD_LATENCY+1 cycles after grant; requesters hold until granted (no buffering here).
module pos_mem_arbiter #(
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int RD_LATENCY   = 2,
  parameter int MAX_WR_BURST = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  output logic                  wr_gnt,
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd0_gnt,
  output logic                  rd1_gnt,
  output logic                  rd_valid,
  output logic                  rd_id,
  output logic [31:0]           rd_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [31:0]           mem_q
);

  localparam int BW = $clog2(MAX_WR_BURST + 1);
  localparam logic [BW-1:0] LP_MAX = BW'(MAX_WR_BURST);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("pos_mem_arbiter: DEPTH must equal 2**ADDR_WIDTH");
  end

  logic                  r_rr_ptr;
  logic [BW-1:0]         r_wr_burst;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [31:0]           r_mem_data;
  logic                  r_mem_rden;
  logic                  r_mem_wren;
  logic [RD_LATENCY:0]   r_tag_vld;
  logic [RD_LATENCY:0]   r_tag_id;

  logic w_any_rd;
  logic w_contested;
  logic w_wr_win;
  logic w_rd_win;
  logic w_rd_id;

  // The writer yields only once it has used up its burst allowance against a waiting reader.
  always_comb begin
    w_any_rd    = rd0_req | rd1_req;
    w_contested = rd0_req & rd1_req;
    w_wr_win    = !rst && wr_req && !((r_wr_burst == LP_MAX) && w_any_rd);
    w_rd_win    = !rst && !w_wr_win && w_any_rd;
    w_rd_id     = w_contested ? r_rr_ptr : rd1_req;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_rr_ptr      <= 1'b0;
      r_wr_burst    <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_rden    <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_tag_vld     <= '0;
      r_tag_id      <= '0;
    end else begin
      if (w_rd_win && w_contested) begin
        r_rr_ptr <= ~r_rr_ptr;
      end

      if (w_rd_win || !w_any_rd) begin
        r_wr_burst <= '0;
      end else if (w_wr_win && (r_wr_burst != LP_MAX)) begin
        r_wr_burst <= r_wr_burst + BW'(1);
      end

      r_mem_wren <= w_wr_win;
      r_mem_rden <= w_rd_win;
      if (w_wr_win) begin
        r_mem_address <= wr_addr;
        r_mem_data    <= wr_data;
      end else if (w_rd_win) begin
        r_mem_address <= w_rd_id ? rd1_addr : rd0_addr;
      end

      // Tags ride alongside the RAM access so the id lines up with mem_q.
      r_tag_vld <= {r_tag_vld[RD_LATENCY-1:0], w_rd_win};
      r_tag_id  <= {r_tag_id[RD_LATENCY-1:0], w_rd_id};
    end
  end

  assign wr_gnt      = w_wr_win;
  assign rd0_gnt     = w_rd_win & ~w_rd_id;
  assign rd1_gnt     = w_rd_win & w_rd_id;
  assign rd_valid    = r_tag_vld[RD_LATENCY];
  assign rd_id       = r_tag_id[RD_LATENCY];
  assign rd_data     = mem_q;
  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign mem_rden    = r_mem_rden;
  assign mem_wren    = r_mem_wren;

endmodule
